// File: rtl/impact_pkg.sv
// Shared definitions for the impact port capture block: register map,
// control/status bit positions and the default FIFO depth.
package impact_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // Word-select within the 16-byte register window (address bits [3:2]).
    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DATA_LO = 2'd2,
        REG_DATA_HI = 2'd3
    } reg_sel_e;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_FULL     = 5;
    localparam int STAT_EMPTY    = 6;
    localparam int STAT_OVERFLOW = 7;

endpackage

// File: rtl/impact_sync_fifo.sv
// Single-clock FIFO holding captured port samples; pop and push may share an
// edge even when full, and clear overrides both.
module impact_sync_fifo
    import impact_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign pop_ok  = pop & ~empty & ~clear;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push & ~clear & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/impact_port_capture.sv
// Captures the {south, west} head outputs into a FIFO on change or every
// cycle, exposed through a four-register Wishbone slave with a level IRQ.
module impact_port_capture
    import impact_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic [31:0] west_i,
    input  logic [31:0] south_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [63:0]   s_q;
    logic [63:0]   p_q;
    logic          enable_reg;
    logic          mode_reg;
    logic          irq_en_reg;
    logic          overflow_reg;
    logic          first_reg;
    logic          ack_reg;
    logic [31:0]   dat_reg;
    logic          irq_reg;

    logic          req;
    logic          in_window;
    reg_sel_e      reg_sel;
    logic          rd_en;
    logic          wr_en;
    logic          ctrl_wr;
    logic          status_wr;
    logic          clear;
    logic          pop;
    logic          push_req;
    logic          overflow_set;
    logic [63:0]   head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [4:0]    count_ext;
    logic [31:0]   rdata_next;
    logic          unused_bits;

    assign unused_bits = ^{wbs_dat_i[31:8], wbs_adr_i[1:0], wbs_sel_i[3:1]};

    // ack_reg gates req so every access acks exactly once, never back-to-back.
    assign req       = wbs_stb_i & wbs_cyc_i & ~ack_reg;
    assign in_window = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign reg_sel   = reg_sel_e'(wbs_adr_i[3:2]);
    assign rd_en     = req & ~wbs_we_i & in_window;
    assign wr_en     = req & wbs_we_i & in_window & wbs_sel_i[0];
    assign ctrl_wr   = wr_en & (reg_sel == REG_CTRL);
    assign status_wr = wr_en & (reg_sel == REG_STATUS);
    assign clear     = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
    assign pop       = rd_en & (reg_sel == REG_DATA_HI) & ~empty;

    assign push_req     = enable_reg & (mode_reg | first_reg | (s_q != p_q));
    assign overflow_set = push_req & full & ~pop & ~clear;
    assign count_ext    = 5'(count);

    impact_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .push  (push_req),
        .pop   (pop),
        .clear (clear),
        .wdata (s_q),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        rdata_next = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_CTRL: begin
                    rdata_next[CTRL_ENABLE] = enable_reg;
                    rdata_next[CTRL_MODE]   = mode_reg;
                    rdata_next[CTRL_IRQ_EN] = irq_en_reg;
                end
                REG_STATUS: begin
                    rdata_next[4:0]           = count_ext;
                    rdata_next[STAT_FULL]     = full;
                    rdata_next[STAT_EMPTY]    = empty;
                    rdata_next[STAT_OVERFLOW] = overflow_reg;
                end
                REG_DATA_LO: rdata_next = empty ? 32'd0 : head[31:0];
                REG_DATA_HI: rdata_next = empty ? 32'd0 : head[63:32];
                default:     rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            s_q          <= '0;
            p_q          <= '0;
            enable_reg   <= 1'b0;
            mode_reg     <= 1'b0;
            irq_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            first_reg    <= 1'b1;
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            irq_reg      <= 1'b0;
        end else begin
            s_q     <= {south_i, west_i};
            p_q     <= s_q;
            ack_reg <= req;
            dat_reg <= rdata_next;
            irq_reg <= irq_en_reg & (~empty | overflow_reg);

            if (ctrl_wr) begin
                enable_reg <= wbs_dat_i[CTRL_ENABLE];
                mode_reg   <= wbs_dat_i[CTRL_MODE];
                irq_en_reg <= wbs_dat_i[CTRL_IRQ_EN];
            end

            // Re-arming enable forces the next sample in even if unchanged.
            if (ctrl_wr & wbs_dat_i[CTRL_ENABLE] & ~enable_reg) begin
                first_reg <= 1'b1;
            end else if (push_req & ~clear) begin
                first_reg <= 1'b0;
            end

            if (clear) begin
                overflow_reg <= 1'b0;
            end else if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (status_wr & wbs_dat_i[STAT_OVERFLOW]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign irq_o     = irq_reg;

endmodule

// File: tb/tb_impact_port_capture.sv
// Directed and randomized checks of impact_port_capture against a queue-based
// reference model that is stepped once per clock edge.
module tb_impact_port_capture;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] west;
    logic [31:0] south;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    impact_port_capture #(
        .DEPTH    (DEPTH),
        .BASE_ADR (BASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .west_i    (west),
        .south_i   (south),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mq[$];
    bit          m_en, m_mode, m_irqen, m_ov, m_first, m_ack, m_irq;
    logic [63:0] m_s, m_p;
    logic [31:0] m_dat;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_mode = 0; m_irqen = 0; m_ov = 0; m_first = 1;
        m_ack = 0; m_irq = 0; m_s = '0; m_p = '0; m_dat = '0;
    endtask

    // One clock edge: predict from pre-edge inputs, then compare outputs.
    task automatic cycle();
        bit          req, inw, rd, wr, clr, pop, push, was_full, ovs;
        logic [1:0]  off;
        logic [63:0] head;
        logic [31:0] rd_v;
        int          sz;
        sz   = mq.size();
        req  = stb && cyc && !m_ack;
        inw  = (adr[31:4] == BASE[31:4]);
        off  = adr[3:2];
        head = (sz != 0) ? mq[0] : 64'd0;
        rd   = req && !we && inw;
        wr   = req && we && inw && sel[0];
        case (off)
            2'd0:    rd_v = {28'd0, m_irqen, 1'b0, m_mode, m_en};
            2'd1:    rd_v = {24'd0, m_ov, sz == 0, sz == DEPTH, 5'(sz)};
            2'd2:    rd_v = head[31:0];
            default: rd_v = head[63:32];
        endcase
        clr  = wr && off == 2'd0 && dat_i[2];
        pop  = rd && off == 2'd3 && sz != 0;
        push = m_en && (m_mode || m_first || m_s != m_p);
        ovs  = 0;
        @(posedge clk);
        m_irq = m_irqen && (sz != 0 || m_ov);
        if (clr) begin
            mq.delete();
        end else begin
            was_full = (sz == DEPTH);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (!was_full || pop) mq.push_back(m_s);
                else ovs = 1;
            end
        end
        if (clr) m_ov = 0;
        else if (ovs) m_ov = 1;
        else if (wr && off == 2'd1 && dat_i[7]) m_ov = 0;
        if (push && !clr) m_first = 0;
        if (wr && off == 2'd0 && dat_i[0] && !m_en) m_first = 1;
        if (wr && off == 2'd0) begin
            m_en = dat_i[0]; m_mode = dat_i[1]; m_irqen = dat_i[3];
        end
        m_ack = req;
        m_dat = rd ? rd_v : 32'd0;
        m_p   = m_s;
        m_s   = {south, west};
        #1;
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("dat", dat_o, m_dat);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] r);
        stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
        cycle();
        r = dat_o;
        chk("ack_pulse", {31'd0, ack}, 32'd1);
        stb = 0; cyc = 0; we = 0;
        cycle();
        chk("ack_drop", {31'd0, ack}, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_access(1'b1, a, d, 4'hF, r);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_access(1'b0, a, 32'd0, 4'hF, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] exp;
        n_cmp = 0; n_err = 0;
        rst_n = 0; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = BASE;
        west = 32'h11; south = 32'h22;
        model_reset();

        // Reset state
        @(posedge clk); #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        #3 rst_n = 1;
        cycle(); cycle();
        wb_read(BASE + 32'h4, r);   chk("status_reset", r, 32'h40);
        wb_read(BASE + 32'h0, r);   chk("ctrl_reset", r, 32'h0);

        // Capture on change: one forced first sample, then one for the change
        wb_write(BASE, 32'h1);
        cycle(); cycle();
        west = 32'h33;
        cycle(); cycle();
        wb_write(BASE, 32'h0);
        wb_read(BASE + 32'h4, r);   chk("chg_status", r, 32'h02);
        wb_read(BASE + 32'h8, r);   chk("chg_lo0", r, 32'h11);
        wb_read(BASE + 32'hC, r);   chk("chg_hi0", r, 32'h22);
        wb_read(BASE + 32'h8, r);   chk("chg_lo1", r, 32'h33);
        wb_read(BASE + 32'hC, r);   chk("chg_hi1", r, 32'h22);
        wb_read(BASE + 32'h4, r);   chk("chg_empty", r, 32'h40);

        // Randomized bus traffic and input activity
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [31:0] a;
            if ($urandom_range(2) == 0) west  = 32'($urandom_range(3));
            if ($urandom_range(5) == 0) south = $urandom;
            a  = ($urandom_range(7) == 0) ? BASE + 32'h40 : BASE + {28'd0, 2'($urandom_range(3)), 2'b00};
            op = $urandom_range(9);
            case (op)
                0: wb_access(1'b1, BASE, $urandom & 32'hB, 4'($urandom_range(15)), r);
                1: wb_read(BASE + 32'hC, r);
                2: wb_read(BASE + 32'h8, r);
                3: wb_read(a, r);
                4: wb_access(1'b1, a, $urandom, 4'($urandom_range(15)), r);
                default: cycle();
            endcase
        end
        wb_write(BASE, 32'h4);
        wb_read(BASE + 32'h4, r);   chk("rand_cleared", r, 32'h40);

        // Every-cycle capture overflows an 8-deep FIFO after 10 pushes
        west = 32'hA5A5_0001; south = 32'h5A5A_0002;
        wb_write(BASE, 32'h3);
        for (int i = 0; i < 8; i++) cycle();
        wb_write(BASE, 32'h2);
        wb_read(BASE + 32'h4, r);   chk("ovf_status", r, 32'hA8);
        wb_write(BASE + 32'h4, 32'h80);
        wb_read(BASE + 32'h4, r);   chk("ovf_w1c", r, 32'h28);

        // Full FIFO: pop coincides with a push
        wb_read(BASE + 32'hC, r);
        wb_write(BASE, 32'h1);
        wb_read(BASE + 32'h4, r);   chk("refill_status", r, 32'h28);
        exp  = mq[0][63:32];
        west = west ^ 32'h1;
        cycle();
        wb_read(BASE + 32'hC, r);   chk("full_pop_oldest", r, exp);
        wb_read(BASE + 32'h4, r);   chk("full_pop_status", r, 32'h28);
        wb_write(BASE, 32'h4);

        // Empty reads and an out-of-window access
        wb_read(BASE + 32'hC, r);   chk("empty_hi", r, 32'h0);
        wb_read(BASE + 32'h4, r);   chk("empty_status", r, 32'h40);
        wb_read(BASE + 32'h20, r);  chk("outside_rd", r, 32'h0);

        // Interrupt timing and clear
        wb_write(BASE, 32'h8);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        wb_write(BASE, 32'h9);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        cycle();
        chk("irq_set", {31'd0, irq}, 32'd1);
        wb_write(BASE, 32'h8);
        wb_read(BASE + 32'hC, r);
        chk("irq_drop", {31'd0, irq}, 32'd0);
        wb_write(BASE, 32'h9);
        west = west ^ 32'h2; cycle(); cycle();
        west = west ^ 32'h4; cycle(); cycle();
        wb_write(BASE, 32'h8);
        wb_read(BASE + 32'h4, r);   chk("three_status", r, 32'h03);
        wb_write(BASE, 32'hC);
        wb_read(BASE + 32'h4, r);   chk("clear_status", r, 32'h40);

        // Reset in the middle of activity
        wb_write(BASE, 32'h9);
        for (int i = 0; i < 4; i++) begin
            west = west + 32'h10;
            cycle();
        end
        cycle();
        wb_read(BASE + 32'h4, r);   chk("five_status", r, 32'h05);
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h4;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_dat", dat_o, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_count", 32'(dut.u_fifo.count), 32'd0);
        stb = 0; cyc = 0;
        @(posedge clk); #1;
        chk("in_rst_ack", {31'd0, ack}, 32'd0);
        #3 rst_n = 1;
        model_reset();
        cycle(); cycle();
        wb_read(BASE + 32'h4, r);   chk("post_rst_status", r, 32'h40);
        wb_write(BASE, 32'h1);
        wb_read(BASE + 32'h4, r);   chk("post_rst_first", r, 32'h01);
        wb_read(BASE + 32'h8, r);   chk("post_rst_lo", r, west);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
